tlc_request_arbiter: RTL

//  Front-end scheduler for the 5-phase intersection light controller.
//  - Debounces the five raw traffic sensors and latches one request per phase.
//  - Picks the next phase to serve: round-robin, with starvation override.
//  - Offers that phase to the light sequencer over a valid/ready grant handshake.
//  - Waits for the sequencer's phase-complete pulse before offering again.

---
 rtl/tlc_request_arbiter_pkg.sv | 36 +++
 rtl/tlc_request_arbiter_sensor_debounce.sv | 40 ++++
 rtl/tlc_request_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tlc_request_arbiter_pkg.sv
// Shared light-controller types: phase encoding, arbiter states and the
// mod-5 phase successor used by the round-robin scan.
package tlc_request_arbiter_pkg;

    typedef enum logic [2:0] {
        PH_S = 3'd0,
        PH_E = 3'd1,
        PH_W = 3'd2,
        PH_L = 3'd3,
        PH_N = 3'd4
    } phase_t;

    localparam int NUM_PHASES = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OFFER   = 2'd1,
        ST_SERVING = 2'd2
    } arb_state_t;

    // Successor phase with an explicit wrap from PH_N back to PH_S, so the
    // 3-bit value never passes through the unused codes 5..7.
    function automatic phase_t next_phase(phase_t p);
        phase_t n;
        case (p)
            PH_S:    n = PH_E;
            PH_E:    n = PH_W;
            PH_W:    n = PH_L;
            PH_L:    n = PH_N;
            PH_N:    n = PH_S;
            default: n = PH_S;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tlc_request_arbiter_sensor_debounce.sv
// Per-sensor debouncer: the clean output rises only after the raw input
// has been high for DEBOUNCE consecutive cycles and drops as soon as it
// goes low.
module sensor_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int            CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic [CW-1:0] count_d;
    logic [CW-1:0] count_q;

    // Count consecutive high cycles, saturating at DEBOUNCE; any low cycle restarts.
    always_comb begin
        count_d = count_q;
        if (!raw) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign clean = (count_q == CNT_MAX);

endmodule

// File: rtl/tlc_request_arbiter.sv
// Front-end scheduler for the 5-phase intersection controller: debounces
// sensors, latches per-phase requests, picks the next phase (round-robin
// with starvation override) and offers it over a valid/ready handshake.
// Optional emergency preemption is enabled by TLC_EMERGENCY_PREEMPT_EN.
module tlc_request_arbiter
    import tlc_request_arbiter_pkg::*;
#(
    parameter int DEBOUNCE = 2,
    parameter int MAX_WAIT = 20,
    parameter int WAIT_W   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_str_sensor,
    input  logic       w_str_sensor,
    input  logic       e_left_sensor,
    input  logic       w_left_sensor,
    input  logic       ns_sensor,
    input  logic       grant_ready,
    input  logic       phase_done,
`ifdef TLC_EMERGENCY_PREEMPT_EN
    input  logic       emerg_req,
    input  logic [2:0] emerg_phase,
    output logic       preempt,
`endif
    output logic       grant_valid,
    output logic [2:0] grant_phase,
    output logic [4:0] pending,
    output logic       starved
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic esClean, wsClean, elClean, wlClean, nsClean;
    logic [NUM_PHASES-1:0] demand;
    logic [NUM_PHASES-1:0] clearMask;
    logic [NUM_PHASES-1:0] serveMask;
    logic [NUM_PHASES-1:0] starvedMask;
    logic                  handshake;
    logic                  offerReq;
    phase_t                winner;
    phase_t                cand;
    logic                  found;

    arb_state_t            state_d, state_q;
    phase_t                grantPhase_d, grantPhase_q;
    phase_t                lastPhase_d, lastPhase_q;
    logic [NUM_PHASES-1:0] pending_d, pending_q;
    logic [WAIT_W-1:0]     waitCnt_d [NUM_PHASES];
    logic [WAIT_W-1:0]     waitCnt_q [NUM_PHASES];

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbEs (.clk(clk), .reset(reset), .raw(e_str_sensor),  .clean(esClean));
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbWs (.clk(clk), .reset(reset), .raw(w_str_sensor),  .clean(wsClean));
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbEl (.clk(clk), .reset(reset), .raw(e_left_sensor), .clean(elClean));
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbWl (.clk(clk), .reset(reset), .raw(w_left_sensor), .clean(wlClean));
    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_dbNs (.clk(clk), .reset(reset), .raw(ns_sensor),     .clean(nsClean));

    assign demand[PH_S] = esClean | wsClean;
    assign demand[PH_E] = elClean | esClean;
    assign demand[PH_W] = wlClean | wsClean;
    assign demand[PH_L] = elClean | wlClean;
    assign demand[PH_N] = nsClean;

    assign handshake = (state_q == ST_OFFER) && grant_ready;

    // Decode which phase is being cleared by a handshake and which is currently offered/served.
    always_comb begin
        clearMask = '0;
        serveMask = '0;
        if (handshake) begin
            clearMask[grantPhase_q] = 1'b1;
        end
        if (state_q != ST_IDLE) begin
            serveMask[grantPhase_q] = 1'b1;
        end
    end

    // Request latch and per-phase wait counters; a handshake clear beats a same-cycle set.
    always_comb begin
        pending_d = (pending_q | demand) & ~clearMask;
        for (int p = 0; p < NUM_PHASES; p++) begin
            waitCnt_d[p]   = waitCnt_q[p];
            starvedMask[p] = pending_q[p] && (waitCnt_q[p] >= WAIT_MAX);
            if (clearMask[p]) begin
                waitCnt_d[p] = '0;
            end else if (pending_q[p] && !serveMask[p] && (waitCnt_q[p] < WAIT_MAX)) begin
                waitCnt_d[p] = waitCnt_q[p] + 1'b1;
            end
        end
    end

    // Winner selection: emergency (if built in), then lowest starved phase, then round-robin after last_phase.
    always_comb begin
        winner   = lastPhase_q;
        found    = 1'b0;
        cand     = lastPhase_q;
        offerReq = |pending_q;
        for (int k = 0; k < NUM_PHASES; k++) begin
            cand = next_phase(cand);
            if (!found && pending_q[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        for (int p = NUM_PHASES - 1; p >= 0; p--) begin
            if (starvedMask[p]) begin
                winner = phase_t'(3'(p));
            end
        end
`ifdef TLC_EMERGENCY_PREEMPT_EN
        if (emerg_req && (emerg_phase <= 3'd4)) begin
            winner   = phase_t'(emerg_phase);
            offerReq = 1'b1;
        end
`endif
    end

    // Arbiter FSM next state: offer a winner, wait for acceptance, then wait for phase completion.
    always_comb begin
        state_d      = state_q;
        grantPhase_d = grantPhase_q;
        lastPhase_d  = lastPhase_q;
        case (state_q)
            ST_IDLE: begin
                if (offerReq) begin
                    grantPhase_d = winner;
                    state_d      = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (grant_ready) begin
                    lastPhase_d = grantPhase_q;
                    state_d     = ST_SERVING;
                end
            end
            ST_SERVING: begin
                if (phase_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, request and counter registers; reset abandons any offer and drops all requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grantPhase_q <= PH_S;
            lastPhase_q  <= PH_N;
            pending_q    <= '0;
            for (int p = 0; p < NUM_PHASES; p++) begin
                waitCnt_q[p] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grantPhase_q <= grantPhase_d;
            lastPhase_q  <= lastPhase_d;
            pending_q    <= pending_d;
            for (int p = 0; p < NUM_PHASES; p++) begin
                waitCnt_q[p] <= waitCnt_d[p];
            end
        end
    end

    assign grant_valid = (state_q == ST_OFFER);
    assign grant_phase = grantPhase_q;
    assign pending     = pending_q;
    assign starved     = |starvedMask;

`ifdef TLC_EMERGENCY_PREEMPT_EN
    assign preempt = (state_q == ST_SERVING) && emerg_req && (emerg_phase <= 3'd4)
                     && (grantPhase_q != phase_t'(emerg_phase));
`endif

endmodule
